stb_capture_buffer: RTL and testbench

- Soft trace buffer on STB0 of the UART debug transport.
- Captures 32-bit probe samples from the target into a FIFO, under host control.
- Host uses the control and data-write channels to configure and arm it, and the status and data-read channels to read state and drain samples.
- Sits directly downstream of the transport's STB0 write outputs and upstream of its STB0 read inputs.

---
 rtl/stb_capture_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_stb_capture_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_capture_buffer.sv
// ---------------------------------------------------------------------------
// stb_capture_buffer
//
// Soft trace buffer hanging off STB0 of the UART debug transport. Probe
// samples from the target are captured into a first-word-fall-through FIFO
// under host control. The host configures and arms the buffer through the
// control and data-write channels, and reads state and drains samples
// through the status and data-read channels.
//
// Ports:
//   CLK_I, RST_I        clock, synchronous active-high reset
//   PROBE_I             sample word from the target
//   PROBE_VALID_I       sample qualifier
//   TRIGGER_I           capture-start event (used while ARMED)
//   CONTROL_VALID_I     host control write valid
//   CONTROL_READY_O     always ready outside reset
//   CONTROL_I           control byte: bit0 ARM, bit1 CLEAR, bit2 CONT
//   WR_DATA_VALID_I     host capture-limit write valid
//   WR_DATA_READY_O     ready only while IDLE
//   WR_DATA_I           capture limit (saturated to DEPTH, 0 means DEPTH)
//   STATUS_VALID_O      always valid outside reset
//   STATUS_READY_I      consumed by host, no side effect
//   STATUS_O            {2'b0, state[1:0], 1'b0, overflow, full, empty}
//   RD_DATA_VALID_O     FIFO not empty
//   RD_DATA_READY_I     pop FIFO head
//   RD_DATA_O           FIFO head word
// ---------------------------------------------------------------------------
module stb_capture_buffer #(
  parameter int STB_CONTROL_WIDTH = 8,
  parameter int STB_STATUS_WIDTH  = 8,
  parameter int STB_DATA_WIDTH    = 32,
  parameter int DEPTH             = 16
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [STB_DATA_WIDTH-1:0]    PROBE_I,
  input  logic                         PROBE_VALID_I,
  input  logic                         TRIGGER_I,
  input  logic                         CONTROL_VALID_I,
  output logic                         CONTROL_READY_O,
  input  logic [STB_CONTROL_WIDTH-1:0] CONTROL_I,
  input  logic                         WR_DATA_VALID_I,
  output logic                         WR_DATA_READY_O,
  input  logic [STB_DATA_WIDTH-1:0]    WR_DATA_I,
  output logic                         STATUS_VALID_O,
  input  logic                         STATUS_READY_I,
  output logic [STB_STATUS_WIDTH-1:0]  STATUS_O,
  output logic                         RD_DATA_VALID_O,
  input  logic                         RD_DATA_READY_I,
  output logic [STB_DATA_WIDTH-1:0]    RD_DATA_O
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Status as seen right after reset: empty FIFO, IDLE, no overflow.
  localparam logic [STB_STATUS_WIDTH-1:0] STATUS_RST = STB_STATUS_WIDTH'(1);

  // Host limit write: clamp to DEPTH so the stored value always fits the
  // limit register; a stored 0 is later read as DEPTH.
  function automatic logic [CW-1:0] sat_limit(input logic [STB_DATA_WIDTH-1:0] v);
    if (v >= STB_DATA_WIDTH'(DEPTH)) begin
      return DEPTH_C;
    end
    return v[CW-1:0];
  endfunction

  logic [1:0]                state_q, state_d;
  logic                      cont_q, cont_d;
  logic [CW-1:0]             count_q, count_d;
  logic [CW-1:0]             limit_q, limit_d;
  logic                      ovf_q, ovf_d;
  logic [CW-1:0]             occ_q, occ_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [STB_STATUS_WIDTH-1:0] status_q, status_d;
  logic [STB_DATA_WIDTH-1:0] mem_q [DEPTH];

  logic          ctrl_arm;
  logic          ctrl_clear;
  logic          ctrl_cont;
  logic          head_valid;
  logic          fifo_full;
  logic [CW-1:0] lim_eff;
  logic [CW-1:0] count_inc;
  logic          take_probe;
  logic          push;
  logic          pop;

  // Upper control bits and the status handshake carry no function.
  logic unused_inputs;
  assign unused_inputs = ^{STATUS_READY_I, CONTROL_I[STB_CONTROL_WIDTH-1:3]};

  assign ctrl_arm   = CONTROL_VALID_I & CONTROL_I[0];
  assign ctrl_clear = CONTROL_VALID_I & CONTROL_I[1];
  assign ctrl_cont  = CONTROL_I[2];

  assign head_valid = (occ_q != '0);
  assign fifo_full  = (occ_q == DEPTH_C);
  assign lim_eff    = (limit_q == '0) ? DEPTH_C : limit_q;
  assign count_inc  = count_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    count_d    = count_q;
    limit_d    = limit_q;
    ovf_d      = ovf_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    take_probe = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    if (WR_DATA_VALID_I && (state_q == ST_IDLE)) begin
      limit_d = sat_limit(WR_DATA_I);
    end

    if (ctrl_clear) begin
      // CLEAR wins over ARM, probe pushes and host pops in the same cycle.
      state_d  = ST_IDLE;
      count_d  = '0;
      ovf_d    = 1'b0;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_arm) begin
            cont_d  = ctrl_cont;
            count_d = '0;
            state_d = ctrl_cont ? ST_CAPTURE : ST_ARMED;
          end
        end
        ST_ARMED: begin
          // A disarm write takes precedence over a coincident trigger.
          if (CONTROL_VALID_I && !CONTROL_I[0]) begin
            state_d = ST_IDLE;
          end else if (TRIGGER_I) begin
            state_d    = ST_CAPTURE;
            take_probe = PROBE_VALID_I;
          end
        end
        ST_CAPTURE: begin
          if (CONTROL_VALID_I && !CONTROL_I[0]) begin
            state_d = ST_IDLE;
          end else begin
            take_probe = PROBE_VALID_I;
          end
        end
        ST_DONE: begin
          // Re-arm keeps FIFO contents; only the capture count restarts.
          if (CONTROL_VALID_I) begin
            if (CONTROL_I[0]) begin
              state_d = ST_ARMED;
              count_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      pop = head_valid & RD_DATA_READY_I;

      if (take_probe) begin
        // A full FIFO still accepts a push when the head leaves this cycle.
        if (fifo_full && !pop) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
        end
        // Dropped samples still count toward a bounded capture.
        if (!cont_q) begin
          count_d = count_inc;
          if (count_inc == lim_eff) begin
            state_d = ST_DONE;
          end
        end
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Status is registered from next-state values so it tracks the state
  // registers cycle for cycle.
  always_comb begin
    status_d      = '0;
    status_d[0]   = (occ_d == '0);
    status_d[1]   = (occ_d == DEPTH_C);
    status_d[2]   = ovf_d;
    status_d[5:4] = state_d;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= ST_IDLE;
      cont_q   <= 1'b0;
      count_q  <= '0;
      limit_q  <= '0;
      ovf_q    <= 1'b0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      status_q <= STATUS_RST;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      ovf_q    <= ovf_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      status_q <= status_d;
    end
  end

  // Sample storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge CLK_I) begin
    if (push && !RST_I) begin
      mem_q[wr_ptr_q] <= PROBE_I;
    end
  end

  // Every output is forced low while reset is asserted.
  assign CONTROL_READY_O = !RST_I;
  assign STATUS_VALID_O  = !RST_I;
  assign STATUS_O        = RST_I ? '0 : status_q;
  assign WR_DATA_READY_O = !RST_I && (state_q == ST_IDLE);
  assign RD_DATA_VALID_O = !RST_I && head_valid;
  assign RD_DATA_O       = RST_I ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_stb_capture_buffer.sv
module tb_stb_capture_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] probe;
  logic        probe_valid;
  logic        trigger;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [7:0]  ctrl;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        status_valid;
  logic        status_ready;
  logic [7:0]  status;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  stb_capture_buffer #(
    .STB_CONTROL_WIDTH(8),
    .STB_STATUS_WIDTH(8),
    .STB_DATA_WIDTH(32),
    .DEPTH(DEPTH)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .PROBE_I(probe),
    .PROBE_VALID_I(probe_valid),
    .TRIGGER_I(trigger),
    .CONTROL_VALID_I(ctrl_valid),
    .CONTROL_READY_O(ctrl_ready),
    .CONTROL_I(ctrl),
    .WR_DATA_VALID_I(wr_valid),
    .WR_DATA_READY_O(wr_ready),
    .WR_DATA_I(wr_data),
    .STATUS_VALID_O(status_valid),
    .STATUS_READY_I(status_ready),
    .STATUS_O(status),
    .RD_DATA_VALID_O(rd_valid),
    .RD_DATA_READY_I(rd_ready),
    .RD_DATA_O(rd_data)
  );

  // Reference model: sample queue plus the host-visible capture state.
  logic [31:0] m_q[$];
  int          m_state;   // 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
  bit          m_cont;
  int          m_count;
  int          m_limit;
  bit          m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    rst          = 1'b0;
    probe        = '0;
    probe_valid  = 1'b0;
    trigger      = 1'b0;
    ctrl_valid   = 1'b0;
    ctrl         = '0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    status_ready = 1'b0;
    rd_ready     = 1'b0;
  endtask

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s = 8'(m_state << 4);
    if (m_ovf) s = s | 8'h04;
    if (m_q.size() == DEPTH) s = s | 8'h02;
    if (m_q.size() == 0) s = s | 8'h01;
    return s;
  endfunction

  task automatic check_outputs();
    if (rst) begin
      check_val("rst_ctrl_ready", ctrl_ready, 0);
      check_val("rst_wr_ready", wr_ready, 0);
      check_val("rst_status_valid", status_valid, 0);
      check_val("rst_status", status, 0);
      check_val("rst_rd_valid", rd_valid, 0);
      check_val("rst_rd_data", rd_data, 0);
    end else begin
      check_val("ctrl_ready", ctrl_ready, 1);
      check_val("status_valid", status_valid, 1);
      check_val("wr_ready", wr_ready, (m_state == 0));
      check_val("status", status, model_status());
      check_val("rd_valid", rd_valid, (m_q.size() != 0));
      if (m_q.size() != 0) check_val("rd_data", rd_data, m_q[0]);
    end
  endtask

  // Advance the model across one clock edge using the driven inputs.
  task automatic model_step();
    bit popping;
    bit sample;
    int lim;
    if (rst) begin
      m_q.delete();
      m_state = 0; m_cont = 0; m_count = 0; m_limit = 0; m_ovf = 0;
      return;
    end
    if (wr_valid && m_state == 0) m_limit = (wr_data >= DEPTH) ? DEPTH : int'(wr_data);
    if (ctrl_valid && ctrl[1]) begin
      m_q.delete();
      m_state = 0; m_count = 0; m_ovf = 0;
      return;
    end
    popping = (m_q.size() > 0) && rd_ready;
    sample  = 0;
    case (m_state)
      0: if (ctrl_valid && ctrl[0]) begin
           m_cont = ctrl[2]; m_count = 0; m_state = ctrl[2] ? 2 : 1;
         end
      1: if (ctrl_valid && !ctrl[0]) m_state = 0;
         else if (trigger) begin m_state = 2; sample = probe_valid; end
      2: if (ctrl_valid && !ctrl[0]) m_state = 0;
         else sample = probe_valid;
      default: if (ctrl_valid) begin
           if (ctrl[0]) begin m_state = 1; m_count = 0; end
           else m_state = 0;
         end
    endcase
    if (sample && m_q.size() == DEPTH && !popping) begin
      m_ovf = 1;
      sample = 0;
      if (!m_cont) m_count++;
    end else if (sample && !m_cont) begin
      m_count++;
    end
    if (popping) void'(m_q.pop_front());
    if (sample) m_q.push_back(probe);
    lim = (m_limit == 0) ? DEPTH : m_limit;
    if (m_state == 2 && !m_cont && m_count == lim) m_state = 3;
  endtask

  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_wr(input logic [7:0] c);
    drive_idle();
    ctrl_valid = 1'b1;
    ctrl       = c;
    tick();
  endtask

  task automatic limit_wr(input logic [31:0] v);
    drive_idle();
    wr_valid = 1'b1;
    wr_data  = v;
    tick();
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      probe_valid = 1'b1;
      probe       = base + 32'(i);
      tick();
    end
  endtask

  task automatic trig_push(input logic [31:0] v);
    drive_idle();
    trigger     = 1'b1;
    probe_valid = 1'b1;
    probe       = v;
    tick();
  endtask

  task automatic drain_check(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      drive_idle();
      check_val("drain_valid", rd_valid, 1);
      check_val("drain_data", rd_data, base + 32'(k));
      rd_ready = 1'b1;
      tick();
    end
    drive_idle();
    #1;
    check_val("drain_empty", rd_valid, 0);
  endtask

  initial begin
    logic [7:0] c;
    drive_idle();
    m_q.delete();
    m_state = 0; m_cont = 0; m_count = 0; m_limit = 0; m_ovf = 0;

    // Reset and idle status.
    rst = 1'b1;
    tick();
    drive_idle();
    #1;
    check_val("post_rst_status", status, 8'h01);
    check_val("post_rst_status_valid", status_valid, 1);
    check_val("post_rst_ctrl_ready", ctrl_ready, 1);

    // Bounded capture of 4 after a trigger; pre-trigger probes ignored.
    limit_wr(32'd4);
    ctrl_wr(8'h01);
    push_n(5, 32'hA0);
    check_val("armed_state", 32'(status[5:4]), 1);
    check_val("armed_empty", status[0], 1);
    trig_push(32'hB0);
    push_n(2, 32'hB1);
    check_val("cap_state", 32'(status[5:4]), 2);
    push_n(1, 32'hB3);
    check_val("done_state", 32'(status[5:4]), 3);
    drain_check(4, 32'hB0);

    // Continuous capture overflowing the FIFO.
    ctrl_wr(8'h00);
    ctrl_wr(8'h05);
    push_n(20, 32'd100);
    check_val("cont_full", status[1], 1);
    check_val("cont_ovf", status[2], 1);
    drain_check(16, 32'd100);

    // Simultaneous push and pop on a full FIFO.
    ctrl_wr(8'h02);
    ctrl_wr(8'h05);
    push_n(16, 32'd200);
    check_val("full_before", status[1], 1);
    check_val("head_before", rd_data, 32'd200);
    drive_idle();
    probe_valid = 1'b1;
    probe       = 32'd300;
    rd_ready    = 1'b1;
    tick();
    check_val("full_after_pp", status[1], 1);
    check_val("ovf_after_pp", status[2], 0);
    check_val("head_after_pp", rd_data, 32'd201);

    // CLEAR+ARM mid-capture, then a saturating limit write.
    ctrl_wr(8'h02);
    ctrl_wr(8'h05);
    push_n(5, 32'd400);
    ctrl_wr(8'h03);
    check_val("clear_status", status, 8'h01);
    check_val("clear_wr_ready", wr_ready, 1);
    limit_wr(32'd100);
    ctrl_wr(8'h01);
    trig_push(32'd500);
    push_n(14, 32'd501);
    check_val("sat_cap_state", 32'(status[5:4]), 2);
    push_n(1, 32'd515);
    check_val("sat_done_state", 32'(status[5:4]), 3);
    ctrl_wr(8'h00);

    // Reset in the middle of a capture.
    ctrl_wr(8'h02);
    ctrl_wr(8'h05);
    push_n(7, 32'd600);
    drive_idle();
    rst = 1'b1;
    #1;
    check_val("midrst_status", status, 0);
    check_val("midrst_status_valid", status_valid, 0);
    check_val("midrst_rd_valid", rd_valid, 0);
    tick();
    drive_idle();
    #1;
    check_val("afterrst_status", status, 8'h01);
    check_val("afterrst_status_valid", status_valid, 1);
    check_val("afterrst_rd_valid", rd_valid, 0);

    // Limit write ignored while ARMED.
    limit_wr(32'd3);
    ctrl_wr(8'h01);
    drive_idle();
    wr_valid = 1'b1;
    wr_data  = 32'd10;
    #1;
    check_val("armed_wr_ready", wr_ready, 0);
    tick();
    trig_push(32'd700);
    push_n(1, 32'd701);
    check_val("oldlim_cap_state", 32'(status[5:4]), 2);
    push_n(1, 32'd702);
    check_val("oldlim_done_state", 32'(status[5:4]), 3);
    ctrl_wr(8'h00);
    ctrl_wr(8'h02);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_idle();
      rst         = ($urandom_range(0, 499) == 0);
      probe       = $urandom;
      probe_valid = $urandom_range(0, 1);
      trigger     = ($urandom_range(0, 7) == 0);
      rd_ready    = ($urandom_range(0, 2) == 0);
      status_ready = $urandom_range(0, 1);
      ctrl_valid  = ($urandom_range(0, 15) == 0);
      c = 8'($urandom_range(0, 255));
      if (c[1] && $urandom_range(0, 3) != 0) c[1] = 1'b0;
      ctrl        = c;
      wr_valid    = ($urandom_range(0, 7) == 0);
      wr_data     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
